a5_1_keystream_gen: RTL

- Consumer side of the A5/1 LFSR register interface. It instantiates or infers three LFSRs: X (19 bit), Y (22 bit) and Z (23 bit).
- It runs the majority-clocking controller across the three registers, which decides per register when to shift (the "trigger").
- It discards a warm-up run, then assembles keystream bits into bytes for the image XOR stage.
- Bytes leave through a valid/ready handshake.

---
 rtl/a5_1_keystream_gen.sv | 137 +++++++++++++
 1 files changed

// File: rtl/a5_1_keystream_gen.sv
// A5/1 keystream generator: three majority-clocked LFSRs (X 19b, Y 22b, Z 23b).
// After a key load it discards WARMUP steps, then packs keystream bits MSB-first
// into OUT_W-bit words that leave through a valid/ready handshake.
module a5_1_keystream_gen #(
    parameter int WARMUP = 100,
    parameter int OUT_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [63:0]      key,
    output logic             ks_valid,
    input  logic             ks_ready,
    output logic [OUT_W-1:0] ks_data,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, WARM, GEN, HOLD} state_t;

    // Last counter values; WARM_LAST is never consulted when WARMUP is zero.
    localparam logic [9:0] WARM_LAST = 10'(WARMUP - 1);
    localparam logic [5:0] LAST_BIT  = 6'(OUT_W - 1);

    state_t state_q, state_d;

    logic [18:0]      x_q;
    logic [21:0]      y_q;
    logic [22:0]      z_q;
    logic [9:0]       warm_cnt_q;
    logic [5:0]       bit_cnt_q;
    logic [OUT_W-1:0] asm_q;
    logic [OUT_W-1:0] asm_next;

    logic maj, ks_bit;
    logic x_fb, y_fb, z_fb;
    logic x_go, y_go, z_go;
    logic do_load, do_step, word_done;

    // Majority vote over the clocking bits, feedback taps and output bit.
    assign maj    = (x_q[8] & y_q[10]) | (x_q[8] & z_q[10]) | (y_q[10] & z_q[10]);
    assign ks_bit = x_q[18] ^ y_q[21] ^ z_q[22];
    assign x_fb   = x_q[18] ^ x_q[17] ^ x_q[16] ^ x_q[13];
    assign y_fb   = y_q[21] ^ y_q[20];
    assign z_fb   = z_q[22] ^ z_q[21] ^ z_q[20] ^ z_q[7];
    assign x_go   = do_step && (x_q[8]  == maj);
    assign y_go   = do_step && (y_q[10] == maj);
    assign z_go   = do_step && (z_q[10] == maj);

    // The assembly register shifts the new bit in at the LSB so the first bit
    // of a word ends up in the MSB.
    generate
        if (OUT_W == 1) begin : g_asm_one
            assign asm_next = ks_bit;
        end else begin : g_asm_wide
            assign asm_next = {asm_q[OUT_W-2:0], ks_bit};
        end
    endgenerate

    assign busy = (state_q != IDLE);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state decode; start overrides everything, including a pending accept.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        state_d   = state_q;
        do_load   = 1'b0;
        do_step   = 1'b0;
        word_done = 1'b0;
        if (start) begin
            do_load = 1'b1;
            state_d = (WARMUP == 0) ? GEN : WARM;
        end else begin
            case (state_q)
                IDLE: ;
                WARM: begin
                    do_step = 1'b1;
                    if (warm_cnt_q == WARM_LAST) state_d = GEN;
                end
                GEN: begin
                    do_step = 1'b1;
                    if (bit_cnt_q == LAST_BIT) begin
                        word_done = 1'b1;
                        state_d   = HOLD;
                    end
                end
                HOLD: if (ks_valid && ks_ready) state_d = GEN;
                default: state_d = IDLE;
            endcase
        end
    end

    // LFSRs, counters, word assembly and the output handshake register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q        <= '0;
            y_q        <= '0;
            z_q        <= '0;
            warm_cnt_q <= '0;
            bit_cnt_q  <= '0;
            asm_q      <= '0;
            ks_data    <= '0;
            ks_valid   <= 1'b0;
        end else if (do_load) begin
            x_q        <= key[63:45];
            y_q        <= key[44:23];
            z_q        <= key[22:0];
            warm_cnt_q <= '0;
            bit_cnt_q  <= '0;
            asm_q      <= '0;
            ks_valid   <= 1'b0;
        end else begin
            if (x_go) x_q <= {x_q[17:0], x_fb};
            if (y_go) y_q <= {y_q[20:0], y_fb};
            if (z_go) z_q <= {z_q[21:0], z_fb};
            if (state_q == WARM) warm_cnt_q <= warm_cnt_q + 10'd1;
            if (state_q == GEN) begin
                asm_q     <= asm_next;
                bit_cnt_q <= word_done ? 6'd0 : bit_cnt_q + 6'd1;
            end
            if (word_done) begin
                ks_data  <= asm_next;
                ks_valid <= 1'b1;
            end else if (state_q == HOLD && ks_valid && ks_ready) begin
                ks_valid <= 1'b0;
            end
        end
    end

endmodule
